// File: rtl/adder_pkg.sv
// Shared types and helpers for the sequential chunked adder/subtractor.
// Holds the FSM state encoding, operation codes and chunk-count helpers.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic bit width_ok(input int width, input int chunk);
    return (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
  endfunction

  function automatic int calc_nchunk(input int width, input int chunk);
    return width_ok(width, chunk) ? (width / chunk) : 1;
  endfunction

endpackage

// File: rtl/seq_chunk_adder_chunk_add.sv
// Combinational CHUNK-bit ripple-carry slice shared by every RUN cycle.
// c_msb exposes the carry into the top bit so the caller can derive signed overflow.
module chunk_add #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [CHUNK:0] cv;

  assign cv[0] = ci;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    assign s[i]    = a[i] ^ b[i] ^ cv[i];
    assign cv[i+1] = (a[i] & b[i]) | (a[i] & cv[i]) | (b[i] & cv[i]);
  end

  assign co    = cv[CHUNK];
  assign c_msb = cv[CHUNK-1];

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands processed CHUNK bits per clock,
// LSB chunk first, with valid/ready handshakes and carry/overflow/zero flags.
module seq_chunk_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if (!width_ok(WIDTH, CHUNK)) begin : g_bad_width
    $error("seq_chunk_adder: WIDTH must be a positive multiple of CHUNK");
  end

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] a_r, b_r;
  logic             carry;
  logic [CHUNK-1:0] s_c;
  logic             co_c, cmsb_c;
  logic [WIDTH-1:0] sum_nxt;
  logic             accept, last;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid & in_ready & ~clear;
  assign last      = (idx == IDX_W'(NCHUNK - 1));

  chunk_add #(.CHUNK(CHUNK)) u_slice (
    .a     (a_r[idx*CHUNK +: CHUNK]),
    .b     (b_r[idx*CHUNK +: CHUNK]),
    .ci    (carry),
    .s     (s_c),
    .co    (co_c),
    .c_msb (cmsb_c)
  );

  // Result with the current chunk merged in; on the last chunk this is the full sum.
  always_comb begin
    sum_nxt = sum;
    sum_nxt[idx*CHUNK +: CHUNK] = s_c;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
    if (clear) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx   <= '0;
      a_r   <= '0;
      b_r   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      zero  <= 1'b0;
    end else if (clear) begin
      idx <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          a_r   <= a;
          b_r   <= (op_sub == OP_SUB) ? ~b : b;
          carry <= (op_sub == OP_SUB) ? 1'b1 : cin;
          idx   <= '0;
        end
        RUN: begin
          sum   <= sum_nxt;
          carry <= co_c;
          idx   <= last ? '0 : idx + IDX_W'(1);
          if (last) begin
            cout <= co_c;
            ovf  <= cmsb_c ^ co_c;
            zero <= (sum_nxt == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Self-checking bench for seq_chunk_adder (WIDTH=16, CHUNK=4): directed corner
// cases, backpressure, clear/reset aborts and randomized ops against an arithmetic model.
module tb_seq_chunk_adder;

  localparam int W   = 16;
  localparam int C   = 4;
  localparam int NCH = W / C;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clear = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         op_sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout, ovf, zero;

  int n_chk  = 0;
  int n_fail = 0;

  seq_chunk_adder #(.WIDTH(W), .CHUNK(C)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_sub    (op_sub),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views.
  function automatic logic [W+2:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic msub, input logic mcin);
    longint ua, ub, sa, sb, u, s;
    logic   co, ov, z;
    logic [W-1:0] r;
    ua = longint'(ma);
    ub = longint'(mb);
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    if (msub) begin
      u  = ua - ub;
      s  = sa - sb;
      co = (ua >= ub);
    end else begin
      u  = ua + ub + longint'(mcin);
      s  = sa + sb + longint'(mcin);
      co = (u >= (longint'(1) << W));
    end
    ov = (s > ((longint'(1) << (W-1)) - 1)) || (s < -(longint'(1) << (W-1)));
    r  = u[W-1:0];
    z  = (r == '0);
    return {co, ov, z, r};
  endfunction

  // Present an op, wait for out_valid and check latency and results; result left pending.
  task automatic start_and_wait(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                                input logic tsub, input logic tcin, input string tag);
    logic [W+2:0] e;
    int cyc;
    e = model(ta, tb_, tsub, tcin);
    @(negedge clk);
    a = ta; b = tb_; op_sub = tsub; cin = tcin; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); op_sub = 1'($urandom); cin = 1'($urandom);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check_eq({tag, "_lat"},  64'(cyc),  64'(NCH));
    check_eq({tag, "_sum"},  64'(sum),  64'(e[W-1:0]));
    check_eq({tag, "_cout"}, 64'(cout), 64'(e[W+2]));
    check_eq({tag, "_ovf"},  64'(ovf),  64'(e[W+1]));
    check_eq({tag, "_zero"}, 64'(zero), 64'(e[W]));
  endtask

  task automatic release_result(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq({tag, "_idle"}, 64'({in_ready, out_valid}), 64'(2'b10));
  endtask

  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                       input logic tsub, input logic tcin, input string tag);
    start_and_wait(ta, tb_, tsub, tcin, tag);
    release_result(tag);
  endtask

  initial begin
    logic [W-1:0] held;
    logic         any_valid;
    logic [W-1:0] ra, rb;
    logic         rs, rc;

    #12;
    check_eq("rst_state", 64'({in_ready, out_valid, cout, ovf, zero}), 64'(5'b10000));
    check_eq("rst_sum", 64'(sum), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    do_op(16'h1234, 16'h4321, 1'b0, 1'b0, "add_basic");
    do_op(16'hFFFF, 16'h0000, 1'b0, 1'b1, "add_ripple");
    do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, "add_ovf");
    do_op(16'h8000, 16'h0001, 1'b1, 1'b0, "sub_ovf");
    do_op(16'h0005, 16'h0007, 1'b1, 1'b0, "sub_borrow");
    do_op(16'h1234, 16'h1234, 1'b1, 1'b1, "sub_zero");

    // Backpressure: result must hold while a new op is offered.
    start_and_wait(16'h0F0F, 16'h00F1, 1'b0, 1'b0, "bp");
    held = sum;
    @(negedge clk);
    in_valid = 1'b1; a = 16'hAAAA; b = 16'h5555; op_sub = 1'b0; cin = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (i == 0 || i == 9) begin
        check_eq("bp_sum", 64'(sum), 64'(held));
        check_eq("bp_hs", 64'({in_ready, out_valid}), 64'(2'b01));
      end
    end
    in_valid = 1'b0;
    release_result("bp");
    do_op(16'hAAAA, 16'h5555, 1'b0, 1'b1, "bp_next");

    // clear on the second RUN cycle aborts the op.
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; op_sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check_eq("clr_idle", 64'({in_ready, out_valid}), 64'(2'b10));
    any_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      any_valid |= out_valid;
    end
    check_eq("clr_noval", 64'(any_valid), 64'(0));
    do_op(16'h0001, 16'h0002, 1'b0, 1'b0, "after_clr");

    for (int k = 0; k < 30; k++) begin
      ra = W'($urandom); rb = W'($urandom);
      rs = 1'($urandom); rc = 1'($urandom);
      if (k % 7 == 3) rb = rs ? ra : ~ra;
      do_op(ra, rb, rs, rc, "rand");
    end

    // Asynchronous reset mid-RUN after a result with nonzero flags.
    do_op(16'hFFFF, 16'hFFFF, 1'b0, 1'b1, "pre_rst");
    @(negedge clk);
    a = 16'h8001; b = 16'h8001; op_sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_eq("arst_flags", 64'({out_valid, cout, ovf, zero}), 64'(4'b0000));
    check_eq("arst_sum", 64'(sum), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("arst_ready", 64'(in_ready), 64'(1));
    do_op(16'h4000, 16'h4000, 1'b0, 1'b0, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
